mem_arbiter: RTL

- Shares the single unified byte-addressed instruction/data memory between two requesters: the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Sits between the multicycle controller/datapath and the memory. It serialises accesses and inserts configurable wait states.
- Each access uses a req/ack handshake.
- Ties are resolved by 2-way round-robin.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arb_rr.sv | 22 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the fetch/load-store arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_adr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic [ADDR_W-1:0] m_adr;
    logic [DATA_W-1:0] m_din;
    logic              m_mrd;
    logic              m_mwr;
    logic [DATA_W-1:0] m_dout;

    logic              busy;

    // Arbiter side
    modport slave (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_dout,
        output i_rdata, i_ack, d_rdata, d_ack, m_adr, m_din, m_mrd, m_mwr, busy
    );

    // Requesters plus memory side
    modport master (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_dout,
        input  i_rdata, i_ack, d_rdata, d_ack, m_adr, m_din, m_mrd, m_mwr, busy
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; on a tie the side that was not served last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (i_req && d_req) begin
            grant_owner = ~last_owner;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one memory,
// inserting WAIT_CYC access cycles and a one-cycle ack per transaction.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    state_e            state_q;
    logic              owner_q;
    logic              last_owner_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [ADDR_W-1:0] m_adr_q;
    logic [DATA_W-1:0] m_din_q;
    logic              m_mrd_q;
    logic              m_mwr_q;
    logic              busy_q;

    logic              grant_valid;
    logic              grant_owner;
    logic              we_d;
    logic [ADDR_W-1:0] adr_d;
    logic [DATA_W-1:0] wdata_d;

    mem_arb_rr u_rr (
        .i_req       (bus.i_req),
        .d_req       (bus.d_req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Fetches are always reads; only the D port may write.
    assign we_d    = (grant_owner == OWN_D) & bus.d_we;
    assign adr_d   = (grant_owner == OWN_D) ? bus.d_adr : bus.i_adr;
    assign wdata_d = bus.d_wdata;

    // m_adr_q/m_din_q double as the latched request for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            m_adr_q      <= '0;
            m_din_q      <= '0;
            m_mrd_q      <= 1'b0;
            m_mwr_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        we_q    <= we_d;
                        cnt_q   <= CNT_LOAD;
                        m_adr_q <= adr_d;
                        m_din_q <= we_d ? wdata_d : '0;
                        m_mrd_q <= ~we_d;
                        m_mwr_q <= we_d && (CNT_LOAD == '0);
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            if (owner_q == OWN_D) begin
                                d_rdata_q <= bus.m_dout;
                            end else begin
                                i_rdata_q <= bus.m_dout;
                            end
                        end
                        last_owner_q <= owner_q;
                        i_ack_q      <= (owner_q == OWN_I);
                        d_ack_q      <= (owner_q == OWN_D);
                        m_adr_q      <= '0;
                        m_din_q      <= '0;
                        m_mrd_q      <= 1'b0;
                        m_mwr_q      <= 1'b0;
                        state_q      <= ACK;
                    end else begin
                        // Raise the write strobe for the final access cycle only.
                        m_mwr_q <= we_q && (cnt_q == CNT_W'(1));
                    end
                end
                ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_rdata = i_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.m_adr   = m_adr_q;
    assign bus.m_din   = m_din_q;
    assign bus.m_mrd   = m_mrd_q;
    assign bus.m_mwr   = m_mwr_q;
    assign bus.busy    = busy_q;

endmodule
